instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 17 +
 rtl/instr_mem_loader_byte_ram.sv | 27 ++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 tb/tb_instr_mem_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// storage geometry.
package instr_mem_loader_pkg;

    localparam int          MEM_BYTES  = 256;
    localparam int          WORD_BYTES = 4;
    localparam logic [7:0]  PAD_BYTE   = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/instr_mem_loader_byte_ram.sv
// 256 x 8 program byte store: one synchronous write port and one
// asynchronous read port per byte lane of an instruction word.
module instr_byte_ram
    import instr_mem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [7:0]                  waddr_i,
    input  logic [7:0]                  wdata_i,
    input  logic [WORD_BYTES-1:0][7:0]  raddr_i,
    output logic [WORD_BYTES-1:0][7:0]  rdata_o
);

    // Contents survive reset; only the loader's pointer/state are cleared.
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_rd
        assign rdata_o[g] = mem_q[raddr_i[g]];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program into byte storage, pads it to a whole number of words,
// then releases the CPU and serves big-endian instruction fetches.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        R,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    input  logic        reload,
    input  logic [7:0]  fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [6:0]  word_count,
    output logic        err_overflow
);

    state_e      state_q, state_d;
    logic [7:0]  wr_ptr_q, wr_ptr_d;
    logic        full_q, full_d;
    logic [6:0]  word_count_q, word_count_d;
    logic        load_done_q, load_done_d;

    logic        we;
    logic [7:0]  wdata;
    logic        word_end;

    logic [WORD_BYTES-1:0][7:0] raddr;
    logic [WORD_BYTES-1:0][7:0] rdata;

    // A write into the last byte lane completes a word.
    assign word_end = (wr_ptr_q[1:0] == 2'b11);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        full_d       = full_q;
        word_count_d = word_count_q;
        we           = 1'b0;
        wdata        = ld_byte;
        ld_ready     = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (full_q) begin
                        state_d = ERR;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 8'd1;
                        if (word_end) begin
                            word_count_d = word_count_q + 7'd1;
                        end
                        if (ld_last) begin
                            state_d = word_end ? DONE : PAD;
                        end else begin
                            state_d = LOAD;
                            if (wr_ptr_q == 8'hFF) begin
                                full_d = 1'b1;
                            end
                        end
                    end
                end
            end
            PAD: begin
                we       = 1'b1;
                wdata    = PAD_BYTE;
                wr_ptr_d = wr_ptr_q + 8'd1;
                if (word_end) begin
                    word_count_d = word_count_q + 7'd1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (reload) begin
                    state_d      = IDLE;
                    wr_ptr_d     = 8'd0;
                    word_count_d = 7'd0;
                end
            end
            ERR: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The program is exposed one cycle after DONE is reached, and withdrawn
    // on the same edge that accepts a reload.
    assign load_done_d = (state_q == DONE) && !reload;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q      <= IDLE;
            wr_ptr_q     <= 8'd0;
            full_q       <= 1'b0;
            word_count_q <= 7'd0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            full_q       <= full_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_addr
        assign raddr[g] = fetch_addr + 8'(g);
    end

    instr_byte_ram u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign fetch_instr  = load_done_q ? {rdata[0], rdata[1], rdata[2], rdata[3]} : 32'h0;
    assign load_done    = load_done_q;
    // The CPU stays held until fetches return real program words.
    assign cpu_hold     = !load_done_q;
    assign word_count   = word_count_q;
    assign err_overflow = (state_q == ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench: byte-count based reference model compared every cycle,
// plus literal expectations for the directed load scenarios.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic        reload = 1'b0;
    logic [7:0]  fetch_addr = 8'h00;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        load_done;
    logic [6:0]  word_count;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;

    instr_mem_loader dut (
        .clk          (clk),
        .R            (R),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .reload       (reload),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: tracks bytes written, whether the last byte was seen,
    // and whether the program has become visible.
    logic [7:0] mmem [256];
    int         m_cnt = 0;
    bit         m_full = 0, m_err = 0, m_ended = 0, m_settled = 0;
    bit         m_complete;
    logic [7:0] fa;
    logic [31:0] exp_instr;

    always @(posedge clk) begin
        if (!R) begin
            m_cnt = 0; m_full = 0; m_err = 0; m_ended = 0; m_settled = 0;
        end else begin
            m_complete = m_ended && (m_cnt % 4 == 0);
            if (m_complete) begin
                if (reload) begin
                    m_cnt = 0; m_ended = 0; m_settled = 0;
                end else begin
                    m_settled = 1;
                end
            end else if (m_err) begin
                m_err = 1;
            end else if (m_ended) begin
                mmem[m_cnt % 256] = 8'h00;
                m_cnt++;
            end else if (ld_valid) begin
                if (m_full) begin
                    m_err = 1;
                end else begin
                    mmem[m_cnt % 256] = ld_byte;
                    m_cnt++;
                    if (ld_last) m_ended = 1;
                    else if (m_cnt == 256) m_full = 1;
                end
            end
        end
        #1;
        fa = fetch_addr;
        exp_instr = m_settled ? {mmem[fa], mmem[fa + 8'd1], mmem[fa + 8'd2], mmem[fa + 8'd3]} : 32'h0;
        chk("m_ld_ready",  ld_ready,     !m_err && !m_ended);
        chk("m_load_done", load_done,    m_settled);
        chk("m_cpu_hold",  cpu_hold,     !m_settled);
        chk("m_err",       err_overflow, m_err);
        chk("m_wcount",    word_count,   m_cnt / 4);
        chk("m_fetch",     fetch_instr,  exp_instr);
    end

    task automatic push(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [7:0] a, input logic [31:0] exp);
        fetch_addr = a;
        #1;
        chk(nm, fetch_instr, exp);
        fetch_addr = 8'h00;
    endtask

    initial begin
        #2 R = 1'b0;
        #1;
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_hold",  cpu_hold, 1'b1);
        chk("rst_done",  load_done, 1'b0);
        chk("rst_wc",    word_count, 7'd0);
        chk("rst_fetch", fetch_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        R = 1'b1;

        // Aligned 8-byte program.
        push(8'hE3, 0); push(8'hA0, 0); push(8'h00, 0); push(8'h01, 0);
        push(8'hE2, 0); push(8'h81, 0); push(8'h10, 0); push(8'h02, 1);
        chk("a_done_early", load_done, 1'b0);
        @(negedge clk);
        chk("a_done", load_done, 1'b1);
        chk("a_wc",   word_count, 7'd2);
        peek("a_f4", 8'd4, 32'hE2811002);
        peek("a_f0", 8'd0, 32'hE3A00001);

        // Reload, then a fresh 4-byte program.
        pulse_reload();
        chk("r_hold",  cpu_hold, 1'b1);
        chk("r_done",  load_done, 1'b0);
        chk("r_fetch", fetch_instr, 32'h0);
        chk("r_wc",    word_count, 7'd0);
        push(8'hCA, 0); push(8'hFE, 0); push(8'hBA, 0); push(8'hBE, 1);
        @(negedge clk);
        chk("r4_done", load_done, 1'b1);
        chk("r4_wc",   word_count, 7'd1);
        peek("r4_f0", 8'd0, 32'hCAFEBABE);

        // 5-byte program needs three pad bytes; offered bytes during PAD are ignored.
        pulse_reload();
        push(8'h11, 0); push(8'h12, 0); push(8'h13, 0); push(8'h14, 0); push(8'h15, 1);
        ld_valid = 1'b1; ld_byte = 8'h77;
        chk("p_ready0", ld_ready, 1'b0);
        @(negedge clk);
        chk("p_ready1", ld_ready, 1'b0);
        @(negedge clk);
        chk("p_ready2", ld_ready, 1'b0);
        @(negedge clk);
        chk("p_done_early", load_done, 1'b0);
        chk("p_wc", word_count, 7'd2);
        ld_valid = 1'b0;
        @(negedge clk);
        chk("p_done", load_done, 1'b1);
        peek("p_f4", 8'd4, 32'h15000000);
        peek("p_f0", 8'd0, 32'h11121314);

        // Full 256-byte program, ld_last on the final byte.
        pulse_reload();
        for (int i = 0; i < 256; i++) push(8'(i), (i == 255));
        chk("f_wc", word_count, 7'd64);
        chk("f_ready", ld_ready, 1'b0);
        @(negedge clk);
        chk("f_done", load_done, 1'b1);
        peek("f_f252", 8'd252, 32'hFCFDFEFF);
        peek("f_f254", 8'd254, 32'hFEFF0001);

        // 257 bytes without ld_last; a reload mid-load is ignored.
        pulse_reload();
        for (int i = 0; i < 10; i++) push(8'(i), 0);
        pulse_reload();
        chk("o_reload_ign", word_count, 7'd2);
        for (int i = 10; i < 256; i++) push(8'(i), 0);
        chk("o_full_err", err_overflow, 1'b0);
        chk("o_full_wc",  word_count, 7'd64);
        push(8'h99, 0);
        chk("o_err",   err_overflow, 1'b1);
        chk("o_hold",  cpu_hold, 1'b1);
        chk("o_ready", ld_ready, 1'b0);
        repeat (3) @(negedge clk);
        pulse_reload();
        chk("o_sticky", err_overflow, 1'b1);
        R = 1'b0;
        #1;
        chk("o_rst_err",   err_overflow, 1'b0);
        chk("o_rst_ready", ld_ready, 1'b1);
        @(negedge clk);
        R = 1'b1;

        // Reset mid-load discards the partial program.
        for (int i = 0; i < 6; i++) push(8'h21 + 8'(i), 0);
        chk("m_wc6", word_count, 7'd1);
        R = 1'b0;
        #1;
        chk("m_rst_wc", word_count, 7'd0);
        @(negedge clk);
        R = 1'b1;
        push(8'hDE, 0); push(8'hAD, 0); push(8'hBE, 0); push(8'hEF, 1);
        @(negedge clk);
        chk("m_done", load_done, 1'b1);
        chk("m_wc",   word_count, 7'd1);
        peek("m_f0", 8'd0, 32'hDEADBEEF);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
